// File: rtl/vend_controller.sv
`default_nettype none
// vend_controller: coin-operated vending FSM with credit, dispense, refund and timeout.
// Revision 1.0
module vend_controller #(
    parameter int PRICE0          = 5,
    parameter int PRICE1          = 8,
    parameter int PRICE2          = 10,
    parameter int PRICE3          = 15,
    parameter int MAX_CREDIT      = 30,
    parameter int DISPENSE_CYCLES = 3,
    parameter int TIMEOUT         = 100
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       coin_valid,
    input  logic [3:0] coin_value,
    input  logic [1:0] select,
    input  logic       buy,
    input  logic       cancel,
    output logic       money_mode,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       error,
    output logic       dispense,
    output logic [1:0] dispense_id,
    output logic       change_valid,
    output logic [7:0] change_value,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DISPENSE_CYCLES + 1);
    localparam logic [8:0]    MAX9      = 9'(MAX_CREDIT);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DISP_LAST = DW'(DISPENSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        VEND     = 3'd2,
        DISPENSE = 3'd3,
        REFUND   = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [7:0]    credit_d, change_value_d;
    logic [1:0]    sel, sel_d, dispense_id_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [DW-1:0] dcnt, dcnt_d;
    logic          reject_d, error_d, change_valid_d;
    logic          money_mode_d, busy_d, dispense_d;
    logic [8:0]    sum;
    logic [7:0]    price;

    always_comb begin
        case (sel)
            2'd0:    price = 8'(PRICE0);
            2'd1:    price = 8'(PRICE1);
            2'd2:    price = 8'(PRICE2);
            default: price = 8'(PRICE3);
        endcase
    end

    assign sum = {1'b0, credit} + {5'b0, coin_value};

    always_comb begin
        state_d        = state;
        credit_d       = credit;
        sel_d          = sel;
        tcnt_d         = tcnt;
        dcnt_d         = dcnt;
        reject_d       = 1'b0;
        error_d        = 1'b0;
        change_value_d = change_value;

        case (state)
            IDLE: begin
                if (coin_valid && coin_value != 4'd0) begin
                    if (sum > MAX9) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum[7:0];
                        state_d  = COLLECT;
                        tcnt_d   = '0;
                    end
                end
                if (buy) error_d = 1'b1;
            end
            COLLECT: begin
                // A coin arriving with buy/cancel loses to the request and is bounced.
                if (cancel) begin
                    state_d  = REFUND;
                    reject_d = coin_valid;
                end else if (buy) begin
                    sel_d    = select;
                    state_d  = VEND;
                    reject_d = coin_valid;
                end else if (coin_valid) begin
                    tcnt_d = '0;
                    if (sum > MAX9) reject_d = 1'b1;
                    else            credit_d = sum[7:0];
                end else if (tcnt == TOUT_LAST) begin
                    state_d = REFUND;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            VEND: begin
                reject_d = coin_valid;
                if (credit >= price) begin
                    credit_d = credit - price;
                    state_d  = DISPENSE;
                    dcnt_d   = '0;
                end else begin
                    error_d = 1'b1;
                    state_d = COLLECT;
                    tcnt_d  = '0;
                end
            end
            DISPENSE: begin
                reject_d = coin_valid;
                if (dcnt == DISP_LAST) state_d = (credit != 8'd0) ? REFUND : IDLE;
                else                   dcnt_d  = dcnt + DW'(1);
            end
            REFUND: begin
                reject_d = coin_valid;
                credit_d = 8'd0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        change_valid_d = (state_d == REFUND);
        if (change_valid_d) change_value_d = credit_d;
        money_mode_d  = (state_d == IDLE) || (state_d == COLLECT);
        busy_d        = !money_mode_d;
        dispense_d    = (state_d == DISPENSE);
        dispense_id_d = dispense_d ? sel_d : 2'd0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            credit       <= 8'd0;
            sel          <= 2'd0;
            tcnt         <= '0;
            dcnt         <= '0;
            money_mode   <= 1'b1;
            coin_reject  <= 1'b0;
            error        <= 1'b0;
            dispense     <= 1'b0;
            dispense_id  <= 2'd0;
            change_valid <= 1'b0;
            change_value <= 8'd0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            credit       <= credit_d;
            sel          <= sel_d;
            tcnt         <= tcnt_d;
            dcnt         <= dcnt_d;
            money_mode   <= money_mode_d;
            coin_reject  <= reject_d;
            error        <= error_d;
            dispense     <= dispense_d;
            dispense_id  <= dispense_id_d;
            change_valid <= change_valid_d;
            change_value <= change_value_d;
            busy         <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// tb_vend_controller: directed scenario bench for vend_controller.
// Revision 1.0
module tb_vend_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = 4'd0;
    logic [1:0] select = 2'd0;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    logic       money_mode, coin_reject, error, dispense, change_valid, busy;
    logic [7:0] credit, change_value;
    logic [1:0] dispense_id;

    int pass = 0;
    int total = 0;

    vend_controller dut (
        .clock(clock), .reset_n(reset_n), .coin_valid(coin_valid), .coin_value(coin_value),
        .select(select), .buy(buy), .cancel(cancel), .money_mode(money_mode),
        .credit(credit), .coin_reject(coin_reject), .error(error), .dispense(dispense),
        .dispense_id(dispense_id), .change_valid(change_valid), .change_value(change_value),
        .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        coin_valid = 1'b0; coin_value = 4'd0; buy = 1'b0; cancel = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (credit !== 8'd0) $display("FAIL rst_credit got %0d exp 0", credit); else pass++;
        total++; if (money_mode !== 1'b1) $display("FAIL rst_money_mode got %b exp 1", money_mode); else pass++;
        total++; if ({coin_reject, error, dispense, change_valid, busy} !== 5'b0)
            $display("FAIL rst_pulses got %b exp 00000", {coin_reject, error, dispense, change_valid, busy}); else pass++;
        total++; if ({dispense_id, change_value} !== 10'd0)
            $display("FAIL rst_id_change got %0d/%0d exp 0/0", dispense_id, change_value); else pass++;
        @(negedge clock);
        reset_n = 1'b1;
        coin_valid = 1'b1; coin_value = 4'd3;
        tick();
        total++; if (credit !== 8'd3) $display("FAIL first_coin credit got %0d exp 3", credit); else pass++;
        cancel = 1'b1; coin_valid = 1'b0;
        tick();
        idle_inputs();
        total++; if (change_value !== 8'd3 || change_valid !== 1'b1)
            $display("FAIL first_refund got %b/%0d exp 1/3", change_valid, change_value); else pass++;
        tick();
    endtask

    task automatic test_idle();
        buy = 1'b1;
        tick();
        idle_inputs();
        total++; if (error !== 1'b1 || busy !== 1'b0 || money_mode !== 1'b1)
            $display("FAIL idle_buy err/busy/mode got %b%b%b exp 101", error, busy, money_mode); else pass++;
        cancel = 1'b1;
        tick();
        idle_inputs();
        total++; if (error !== 1'b0 || change_valid !== 1'b0)
            $display("FAIL idle_cancel err/cv got %b%b exp 00", error, change_valid); else pass++;
        coin_valid = 1'b1; coin_value = 4'd0;
        tick();
        idle_inputs();
        tick();
        total++; if (credit !== 8'd0 || busy !== 1'b0 || change_valid !== 1'b0)
            $display("FAIL zero_coin credit/busy/cv got %0d/%b/%b exp 0/0/0", credit, busy, change_valid); else pass++;
    endtask

    task automatic test_purchase();
        coin_valid = 1'b1; coin_value = 4'd5;
        tick();
        total++; if (credit !== 8'd5) $display("FAIL buy_coin1 credit got %0d exp 5", credit); else pass++;
        coin_value = 4'd10;
        tick();
        total++; if (credit !== 8'd15) $display("FAIL buy_coin2 credit got %0d exp 15", credit); else pass++;
        coin_valid = 1'b0; select = 2'd1; buy = 1'b1;
        tick();
        idle_inputs();
        total++; if (busy !== 1'b1 || money_mode !== 1'b0 || dispense !== 1'b0)
            $display("FAIL buy_vend busy/mode/disp got %b%b%b exp 100", busy, money_mode, dispense); else pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (dispense !== 1'b1 || dispense_id !== 2'd1 || credit !== 8'd7)
                $display("FAIL buy_disp%0d disp/id/credit got %b/%0d/%0d exp 1/1/7", i, dispense, dispense_id, credit); else pass++;
        end
        tick();
        total++; if (dispense !== 1'b0 || change_valid !== 1'b1 || change_value !== 8'd7)
            $display("FAIL buy_refund disp/cv/val got %b/%b/%0d exp 0/1/7", dispense, change_valid, change_value); else pass++;
        tick();
        total++; if (credit !== 8'd0 || change_valid !== 1'b0 || busy !== 1'b0 || money_mode !== 1'b1)
            $display("FAIL buy_idle credit/cv/busy/mode got %0d/%b/%b/%b exp 0/0/0/1", credit, change_valid, busy, money_mode); else pass++;
    endtask

    task automatic test_insufficient();
        coin_valid = 1'b1; coin_value = 4'd5;
        tick();
        coin_valid = 1'b0; select = 2'd3; buy = 1'b1;
        tick();
        idle_inputs();
        tick();
        total++; if (error !== 1'b1 || credit !== 8'd5 || money_mode !== 1'b1 || busy !== 1'b0)
            $display("FAIL short_err err/credit/mode/busy got %b/%0d/%b/%b exp 1/5/1/0", error, credit, money_mode, busy); else pass++;
        cancel = 1'b1;
        tick();
        idle_inputs();
        total++; if (error !== 1'b0 || change_valid !== 1'b1 || change_value !== 8'd5)
            $display("FAIL short_cancel err/cv/val got %b/%b/%0d exp 0/1/5", error, change_valid, change_value); else pass++;
        tick();
    endtask

    task automatic test_overflow();
        coin_valid = 1'b1; coin_value = 4'd15;
        tick();
        tick();
        total++; if (credit !== 8'd30 || coin_reject !== 1'b0)
            $display("FAIL ovf_fill credit/rej got %0d/%b exp 30/0", credit, coin_reject); else pass++;
        coin_value = 4'd4;
        tick();
        idle_inputs();
        total++; if (credit !== 8'd30 || coin_reject !== 1'b1)
            $display("FAIL ovf_reject credit/rej got %0d/%b exp 30/1", credit, coin_reject); else pass++;
        cancel = 1'b1;
        tick();
        idle_inputs();
        tick();
        total++; if (credit !== 8'd0 || coin_reject !== 1'b0)
            $display("FAIL ovf_clear credit/rej got %0d/%b exp 0/0", credit, coin_reject); else pass++;
    endtask

    task automatic test_coin_with_cancel();
        coin_valid = 1'b1; coin_value = 4'd6;
        tick();
        coin_value = 4'd4; cancel = 1'b1;
        tick();
        idle_inputs();
        total++; if (coin_reject !== 1'b1 || change_valid !== 1'b1 || change_value !== 8'd6)
            $display("FAIL coin_cancel rej/cv/val got %b/%b/%0d exp 1/1/6", coin_reject, change_valid, change_value); else pass++;
        tick();
    endtask

    task automatic test_coin_while_busy();
        coin_valid = 1'b1; coin_value = 4'd10;
        tick();
        coin_valid = 1'b0; select = 2'd0; buy = 1'b1;
        tick();
        buy = 1'b0; coin_valid = 1'b1; coin_value = 4'd5;
        tick();
        idle_inputs();
        total++; if (coin_reject !== 1'b1 || credit !== 8'd5 || dispense !== 1'b1 || dispense_id !== 2'd0)
            $display("FAIL busy_coin rej/credit/disp/id got %b/%0d/%b/%0d exp 1/5/1/0", coin_reject, credit, dispense, dispense_id); else pass++;
        repeat (3) tick();
        total++; if (change_valid !== 1'b1 || change_value !== 8'd5)
            $display("FAIL busy_refund cv/val got %b/%0d exp 1/5", change_valid, change_value); else pass++;
        tick();
    endtask

    task automatic test_timeout();
        coin_valid = 1'b1; coin_value = 4'd8;
        tick();
        idle_inputs();
        repeat (99) tick();
        total++; if (change_valid !== 1'b0 || money_mode !== 1'b1)
            $display("FAIL tout_early cv/mode got %b/%b exp 0/1", change_valid, money_mode); else pass++;
        tick();
        total++; if (change_valid !== 1'b1 || change_value !== 8'd8 || busy !== 1'b1)
            $display("FAIL tout_refund cv/val/busy got %b/%0d/%b exp 1/8/1", change_valid, change_value, busy); else pass++;
        tick();
        total++; if (credit !== 8'd0 || busy !== 1'b0 || change_valid !== 1'b0)
            $display("FAIL tout_idle credit/busy/cv got %0d/%b/%b exp 0/0/0", credit, busy, change_valid); else pass++;
    endtask

    task automatic test_reset_mid_dispense();
        int seen;
        coin_valid = 1'b1; coin_value = 4'd10;
        tick();
        coin_valid = 1'b0; select = 2'd2; buy = 1'b1;
        tick();
        idle_inputs();
        tick();
        total++; if (dispense !== 1'b1 || dispense_id !== 2'd2)
            $display("FAIL rstd_pre disp/id got %b/%0d exp 1/2", dispense, dispense_id); else pass++;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (dispense !== 1'b0 || credit !== 8'd0 || money_mode !== 1'b1 || change_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rstd_async disp/credit/mode/cv/busy got %b/%0d/%b/%b/%b exp 0/0/1/0/0",
                     dispense, credit, money_mode, change_valid, busy); else pass++;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (change_valid === 1'b1 || dispense === 1'b1) seen++;
        end
        total++; if (seen !== 0 || credit !== 8'd0)
            $display("FAIL rstd_after pulses/credit got %0d/%0d exp 0/0", seen, credit); else pass++;
    endtask

    initial begin
        #12;
        test_reset();
        test_idle();
        test_purchase();
        test_insufficient();
        test_overflow();
        test_coin_with_cancel();
        test_coin_while_busy();
        test_timeout();
        test_reset_mid_dispense();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
`default_nettype wire
